// File: rtl/rxfifo_pkg.sv
// ---------------------------------------------------------------------------
// rxfifo_pkg -- shared constants for the UART receive path.
//
// Contents:
//   RX_DATA_W      default byte width produced by the deserializer (8)
//   RX_BAUD_DIV    baud divisor, 10 MHz system clock / 115200 baud (87)
//   RX_DEPTH_LOG2  log2 of the receive FIFO depth (4 -> 16 entries)
//   RX_AF_LEVEL    default occupancy threshold for the FIFO interrupt
//   rx_fifo_depth  helper turning a log2 depth into an entry count
// ---------------------------------------------------------------------------
package rxfifo_pkg;

    localparam int RX_DATA_W     = 8;
    localparam int RX_BAUD_DIV   = 87;
    localparam int RX_DEPTH_LOG2 = 4;
    localparam int RX_AF_LEVEL   = 12;

    function automatic int rx_fifo_depth(input int depth_log2);
        return 1 << depth_log2;
    endfunction

endpackage

// File: rtl/rxfifo_if.sv
// ---------------------------------------------------------------------------
// rxfifo_if -- bundle of the receive FIFO data/handshake signals.
//
// Signals:
//   i_Rx_Data  byte from the deserializer, valid while i_Rx_Done is high
//   i_Rx_Done  done flag from the deserializer (pulse or held level)
//   i_Rd_En    pop request, one byte per cycle while high
//   i_Clr_Ovr  clears the sticky overrun flag
//   o_Rd_Data  head-of-queue byte (show-ahead)
//   o_Empty    FIFO empty
//   o_Full     FIFO full
//   o_Count    current occupancy 0..2^DEPTH_LOG2
//   o_Overrun  sticky dropped-byte flag
//   o_Irq      threshold interrupt
//
// Modports:
//   master  the side that feeds bytes and pops them (deserializer + host)
//   slave   the FIFO itself
// ---------------------------------------------------------------------------
interface rxfifo_if
    import rxfifo_pkg::*;
#(
    parameter int DATA_W     = RX_DATA_W,
    parameter int DEPTH_LOG2 = RX_DEPTH_LOG2
);
    logic [DATA_W-1:0]   i_Rx_Data;
    logic                i_Rx_Done;
    logic                i_Rd_En;
    logic                i_Clr_Ovr;
    logic [DATA_W-1:0]   o_Rd_Data;
    logic                o_Empty;
    logic                o_Full;
    logic [DEPTH_LOG2:0] o_Count;
    logic                o_Overrun;
    logic                o_Irq;

    modport master (
        output i_Rx_Data, i_Rx_Done, i_Rd_En, i_Clr_Ovr,
        input  o_Rd_Data, o_Empty, o_Full, o_Count, o_Overrun, o_Irq
    );

    modport slave (
        input  i_Rx_Data, i_Rx_Done, i_Rd_En, i_Clr_Ovr,
        output o_Rd_Data, o_Empty, o_Full, o_Count, o_Overrun, o_Irq
    );

endinterface

// File: rtl/rxfifo_edge.sv
// ---------------------------------------------------------------------------
// rxfifo_edge -- rising-edge detector for done flags.
//
// A flag held high for many cycles yields a single-cycle o_Rise on the
// first high cycle. Works per bit, so one instance can watch several
// independent flags (e.g. receive and transmit done).
//
// Ports:
//   i_Pclk     system clock, rising edge
//   i_Presetn  synchronous active-low reset (clears the history register)
//   i_Flag     flags to watch
//   o_Rise     1 for each bit that is high now and was low last cycle
// ---------------------------------------------------------------------------
module rxfifo_edge #(
    parameter int W = 1
) (
    input  logic         i_Pclk,
    input  logic         i_Presetn,
    input  logic [W-1:0] i_Flag,
    output logic [W-1:0] o_Rise
);

    logic [W-1:0] r_prev;

    always_ff @(posedge i_Pclk) begin
        if (!i_Presetn) begin
            r_prev <= '0;
        end else begin
            r_prev <= i_Flag;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < W; gi++) begin : g_rise
            assign o_Rise[gi] = i_Flag[gi] & ~r_prev[gi];
        end
    endgenerate

endmodule

// File: rtl/rxfifo.sv
// ---------------------------------------------------------------------------
// rxfifo -- receive buffer downstream of the rxshift deserializer.
//
// Captures a byte on every rising edge of the done flag and queues it in a
// circular buffer read through a show-ahead port. Tracks occupancy and a
// sticky overrun flag for bytes dropped while full.
//
// Build option:
//   RXFIFO_IRQ_EN  when defined, o_Irq is a registered interrupt that is
//                  high while occupancy >= AF_LEVEL or overrun is set.
//                  When undefined, o_Irq is tied low and AF_LEVEL does not
//                  exist.
//
// Ports:
//   i_Pclk     system clock, rising edge
//   i_Presetn  synchronous active-low reset
//   bus        rxfifo_if.slave: data/done in, pop/clear in, status out
// ---------------------------------------------------------------------------
module rxfifo
    import rxfifo_pkg::*;
#(
    parameter int DATA_W     = RX_DATA_W,
    parameter int DEPTH_LOG2 = RX_DEPTH_LOG2
`ifdef RXFIFO_IRQ_EN
    ,
    parameter int AF_LEVEL   = RX_AF_LEVEL
`endif
) (
    input  logic     i_Pclk,
    input  logic     i_Presetn,
    rxfifo_if.slave  bus
);

    localparam int DEPTH = rx_fifo_depth(DEPTH_LOG2);
    localparam int CNT_W = DEPTH_LOG2 + 1;

    logic [DATA_W-1:0]     r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [CNT_W-1:0]      r_count;
    logic                  r_overrun;

    logic w_wr_edge;
    logic w_full;
    logic w_empty;
    logic w_rd_ok;
    logic w_wr_ok;
    logic w_drop;

    rxfifo_edge #(
        .W (1)
    ) u_edge (
        .i_Pclk    (i_Pclk),
        .i_Presetn (i_Presetn),
        .i_Flag    (bus.i_Rx_Done),
        .o_Rise    (w_wr_edge)
    );

    // Status comes straight from the registered count, so it is glitch-free.
    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_empty = (r_count == '0);

    assign w_rd_ok = bus.i_Rd_En & ~w_empty;
    // When full, a same-cycle pop frees the slot the write lands in.
    assign w_wr_ok = w_wr_edge & (~w_full | w_rd_ok);
    assign w_drop  = w_wr_edge & w_full & ~w_rd_ok;

    always_ff @(posedge i_Pclk) begin
        if (!i_Presetn) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_wr_ok) begin
                r_wr_ptr <= r_wr_ptr + DEPTH_LOG2'(1);
            end
            if (w_rd_ok) begin
                r_rd_ptr <= r_rd_ptr + DEPTH_LOG2'(1);
            end
            case ({w_wr_ok, w_rd_ok})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            // A drop in the same cycle as a clear leaves the flag set.
            if (w_drop) begin
                r_overrun <= 1'b1;
            end else if (bus.i_Clr_Ovr) begin
                r_overrun <= 1'b0;
            end
        end
    end

    // Storage is not reset; pointers alone define what is valid.
    always_ff @(posedge i_Pclk) begin
        if (i_Presetn && w_wr_ok) begin
            r_mem[r_wr_ptr] <= bus.i_Rx_Data;
        end
    end

    assign bus.o_Rd_Data = r_mem[r_rd_ptr];
    assign bus.o_Empty   = w_empty;
    assign bus.o_Full    = w_full;
    assign bus.o_Count   = r_count;
    assign bus.o_Overrun = r_overrun;

`ifdef RXFIFO_IRQ_EN
    logic r_irq;

    // Built from registered state, so it trails count/overrun by a cycle.
    always_ff @(posedge i_Pclk) begin
        if (!i_Presetn) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= (r_count >= CNT_W'(AF_LEVEL)) | r_overrun;
        end
    end

    assign bus.o_Irq = r_irq;
`else
    assign bus.o_Irq = 1'b0;
`endif

endmodule

// File: doc/rxfifo.md
Name: rxfifo

Overview:
- Receive buffer directly downstream of the rxshift deserializer. It captures each completed byte on the rising edge of the deserializer's done flag and queues it in a circular FIFO.
- The host side pops bytes through a show-ahead read port.
- Tracks occupancy, flags overrun when a byte arrives while full, and optionally raises a threshold interrupt.

Parameters:
- DATA_W, 8, byte width; matches the rxshift data output.
- DEPTH_LOG2, 4, log2 of FIFO depth (default depth 16).
- AF_LEVEL, 12, occupancy at or above which the threshold interrupt asserts (only used with RXFIFO_IRQ_EN).

Ports:
- i_Pclk  in  1  system clock, rising-edge.
- i_Presetn  in  1  synchronous active-low reset.
- i_Rx_Data  in  DATA_W  byte from rxshift; valid when i_Rx_Done is high.
- i_Rx_Done  in  1  done flag from rxshift; may be a single-cycle pulse or a held level.
- i_Rd_En  in  1  pop request; one byte per cycle while high.
- i_Clr_Ovr  in  1  clears the sticky overrun flag.
- o_Rd_Data  out  DATA_W  head-of-queue byte (show-ahead); valid when o_Empty=0.
- o_Empty  out  1  FIFO empty.
- o_Full  out  1  FIFO full.
- o_Count  out  DEPTH_LOG2+1  current occupancy, 0..2^DEPTH_LOG2.
- o_Overrun  out  1  sticky: at least one byte was dropped.
- o_Irq  out  1  threshold interrupt; tied 0 when the feature is compiled out.

Behaviour:
- Reset (i_Presetn=0 at a rising clock edge):
  - Pointers and count go to 0; o_Empty=1; o_Full=0; o_Count=0; o_Overrun=0; o_Irq=0.
  - The done edge-detect register goes to 0.
  - Memory contents are not reset; o_Rd_Data is don't-care while empty.
  - Reset mid-operation discards all queued bytes.
- Write event:
  - Condition: i_Rx_Done=1 and the registered previous i_Rx_Done=0.
  - A done level held for N cycles produces exactly one write.
  - i_Rx_Data is sampled in the same cycle as the edge.
- Read event: i_Rd_En=1 and o_Empty=0. A read while empty is ignored, with no pointer change and no error flag.
- Storage: circular buffer with DEPTH_LOG2-bit read and write pointers that wrap naturally modulo depth. o_Count is a separate DEPTH_LOG2+1-bit counter.
- Show-ahead read port:
  - o_Rd_Data = mem[rd_ptr], combinational from the registered pointer.
  - A byte written at edge k appears on o_Rd_Data, and o_Empty falls, after edge k (one-cycle write-to-read latency).
  - A read at edge k advances the head after edge k.
- Write only: accepted if not full (wr_ptr+1, count+1). If full, the byte is dropped and o_Overrun is set.
- Read only: rd_ptr+1, count-1.
- Simultaneous write and read:
  - Not empty: both occur; count unchanged.
  - Full: both occur, no overrun; the write lands in the slot the read frees.
  - Empty: the read is ignored; the write is accepted; count becomes 1.
- o_Full = (count == 2^DEPTH_LOG2); o_Empty = (count == 0). Both are registered or derived from the registered count, so they are glitch-free.
- Overrun flag:
  - Set on a dropped write; stays set until i_Clr_Ovr=1.
  - If a clear and a new drop occur in the same cycle, the set wins.

Optional Feature:
- Macro: RXFIFO_IRQ_EN.
- Defined: o_Irq is registered and is 1 when o_Count >= AF_LEVEL or o_Overrun=1; otherwise 0. It updates one cycle after the count or flag change.
- Undefined: o_Irq is tied 0. The AF_LEVEL compare logic is not synthesized.

Decomposition:
- Shared package/include for the UART receive path:
  - Default DATA_W=8.
  - Baud divisor constant 87 (10 MHz / 115200).
  - FIFO depth constant.
- One natural sub-module, rxfifo_edge: a rising-edge detector on i_Rx_Done, also reusable for the transmit-side done flag.
- The memory array and pointer logic stay in rxfifo.

Test Plan:
- Reset, then write 0xA5 with a single-cycle i_Rx_Done pulse -> the next cycle shows o_Rd_Data=0xA5, o_Empty=0, o_Count=1. Pulse i_Rd_En -> o_Empty=1, o_Count=0.
- Hold i_Rx_Done high for 87 cycles with data 0x3C -> exactly one write; o_Count=1.
- Write 16 bytes 0x00..0x0F -> o_Full=1, o_Count=16. A 17th write of 0xFF -> dropped; o_Overrun=1; reads return 0x00..0x0F in order. i_Clr_Ovr -> o_Overrun=0.
- Full FIFO with a simultaneous write edge (0x55) and i_Rd_En -> o_Overrun stays 0; o_Count=16; 0x55 is read last after the other 15 bytes.
- Empty FIFO with i_Rd_En plus a write edge (0x77) -> o_Count=1; o_Rd_Data=0x77. Apply i_Presetn=0 with 5 bytes queued -> o_Count=0, o_Empty=1.
- RXFIFO_IRQ_EN defined, AF_LEVEL=12: write 11 bytes -> o_Irq=0; the 12th write -> o_Irq=1 one cycle later; read 1 byte -> o_Irq=0. Undefined: o_Irq=0 throughout.
